// File: rtl/vga_vram_arbiter_if.sv
// Pixel-write request channel into the VGA framebuffer arbiter.
// The requester (master) offers a pixel; the arbiter (slave) answers with wr_ready.
interface vga_vram_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              wr_valid;
  logic              wr_ready;
  logic [7:0]        wr_x;
  logic [6:0]        wr_y;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_valid, output wr_x, output wr_y, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_x, input wr_y, input wr_data, output wr_ready);
endinterface

// File: rtl/vga_vram_arbiter.sv
// Single-port 160x120 framebuffer arbiter for 640x480 VGA.
// Display reads take every 4th active pixel slot; all remaining slots go to
// either the screen-clear engine or the pixel-write requester. Scan-out data
// is re-aligned with the delayed sync/active signals.
module vga_vram_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DATA_W   = 8
) (
  input  logic              clk_25,
  input  logic              rst,
  input  logic [9:0]        x_count,
  input  logic [9:0]        y_count,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              active_in,
  input  logic              cfg_vblank_only,
  vga_vram_arbiter_if.slave wr,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
  output logic [14:0]       mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pixel_rgb,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              active_out
);

  localparam logic [9:0]  H_LIM     = 10'(H_ACTIVE);
  localparam logic [9:0]  V_LIM     = 10'(V_ACTIVE);
  localparam logic [7:0]  FB_W      = 8'd160;
  localparam logic [6:0]  FB_H      = 7'd120;
  localparam logic [14:0] LAST_ADDR = 15'd19199;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [14:0]       clr_ptr;
  logic [DATA_W-1:0] clr_color;

  logic              disp;
  logic              free;
  logic              in_vblank;
  logic              wr_in_range;
  logic              accept;
  logic [14:0]       disp_addr;
  logic [14:0]       wr_addr;

  logic              vld_p1;
  logic [DATA_W-1:0] pix_p2;
  logic              hsync_p2;
  logic              vsync_p2;
  logic              active_p2;

  // y*160 + x as two shifts and an add; inputs are framebuffer coordinates
  function automatic logic [14:0] fb_addr(input logic [6:0] y, input logic [7:0] x);
    logic [14:0] y_ext;
    y_ext   = {8'd0, y};
    fb_addr = (y_ext << 7) + (y_ext << 5) + {7'd0, x};
  endfunction

  assign disp        = (x_count < H_LIM) && (y_count < V_LIM) && (x_count[1:0] == 2'b00);
  assign free        = !disp;
  assign in_vblank   = (y_count >= V_LIM);
  assign disp_addr   = fb_addr(y_count[8:2], x_count[9:2]);
  assign wr_addr     = fb_addr(wr.wr_y, wr.wr_x);
  assign wr_in_range = (wr.wr_x < FB_W) && (wr.wr_y < FB_H);

  // A clear request in the same cycle takes precedence over the requester
  assign wr.wr_ready = !rst && (state == IDLE) && free && !clear_start &&
                       (!cfg_vblank_only || in_vblank);
  assign accept      = wr.wr_valid && wr.wr_ready;

  // RAM port mux: display read, else clear fill, else requester write
  always_comb begin
    mem_addr  = wr_addr;
    mem_we    = 1'b0;
    mem_wdata = wr.wr_data;
    if (disp) begin
      mem_addr = disp_addr;
    end else if (state == CLEAR) begin
      mem_addr  = clr_ptr;
      mem_wdata = clr_color;
      mem_we    = !rst;
    end else if (accept && wr_in_range) begin
      mem_we = 1'b1;
    end
  end

  // Control FSM: clear runs until the last framebuffer address is written
  always_ff @(posedge clk_25) begin
    if (rst) begin
      state      <= IDLE;
      clear_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_start) begin
            state      <= CLEAR;
            clear_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (free && (clr_ptr == LAST_ADDR)) begin
            state      <= IDLE;
            clear_busy <= 1'b0;
          end
        end
      endcase
    end
  end

  // Clear pointer and fill colour; pointer advances once per free slot
  always_ff @(posedge clk_25) begin
    if ((state == IDLE) && clear_start) begin
      clr_ptr   <= '0;
      clr_color <= clear_color;
    end else if ((state == CLEAR) && free) begin
      clr_ptr <= clr_ptr + 15'd1;
    end
  end

  // ---- p0 -> p1: the RAM returns data for the display slot issued in p0 ----
  // Track which cycles carry display read data
  always_ff @(posedge clk_25) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= disp;
  end

  // ---- p1 -> p2: pixel register, held across the 4-pixel group ----
  // Capture returned pixel only on the cycle after a display slot
  always_ff @(posedge clk_25) begin
    if (vld_p1) pix_p2 <= mem_rdata;
  end

  // Sync/active already lag the counters by one; one more register aligns them with pix_p2
  always_ff @(posedge clk_25) begin
    if (rst) begin
      hsync_p2  <= 1'b1;
      vsync_p2  <= 1'b1;
      active_p2 <= 1'b0;
    end else begin
      hsync_p2  <= hsync_in;
      vsync_p2  <= vsync_in;
      active_p2 <= active_in;
    end
  end

  assign pixel_rgb  = active_p2 ? pix_p2 : '0;
  assign hsync_out  = hsync_p2;
  assign vsync_out  = vsync_p2;
  assign active_out = active_p2;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed testbench for vga_vram_arbiter with a behavioural RAM model.
module tb_vga_vram_arbiter;

  logic       clk_25 = 1'b0;
  logic       rst;
  logic [9:0] x_count;
  logic [9:0] y_count;
  logic       hsync_in;
  logic       vsync_in;
  logic       active_in;
  logic       cfg_vblank_only;
  logic       clear_start;
  logic [7:0] clear_color;
  logic       clear_busy;
  logic [14:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [7:0] pixel_rgb;
  logic       hsync_out;
  logic       vsync_out;
  logic       active_out;

  always #20 clk_25 = ~clk_25;

  vga_vram_arbiter_if #(.DATA_W(8)) wr_if ();

  vga_vram_arbiter #(.H_ACTIVE(640), .V_ACTIVE(480), .DATA_W(8)) dut (
    .clk_25          (clk_25),
    .rst             (rst),
    .x_count         (x_count),
    .y_count         (y_count),
    .hsync_in        (hsync_in),
    .vsync_in        (vsync_in),
    .active_in       (active_in),
    .cfg_vblank_only (cfg_vblank_only),
    .wr              (wr_if),
    .clear_start     (clear_start),
    .clear_color     (clear_color),
    .clear_busy      (clear_busy),
    .mem_addr        (mem_addr),
    .mem_we          (mem_we),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .pixel_rgb       (pixel_rgb),
    .hsync_out       (hsync_out),
    .vsync_out       (vsync_out),
    .active_out      (active_out)
  );

  // Single-port RAM: write on the edge, registered read
  logic [7:0] ram [0:32767] = '{default: 8'h00};
  always @(posedge clk_25) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Clear-engine monitor: write order and slot legality
  logic mon_en = 1'b0;
  int   clr_cnt = 0;
  int   clr_err = 0;
  int   disp_err = 0;
  always @(negedge clk_25) begin
    if (mon_en && mem_we) begin
      if (mem_addr != 15'(clr_cnt)) clr_err <= clr_err + 1;
      if (x_count < 640 && y_count < 480 && x_count[1:0] == 2'b00) disp_err <= disp_err + 1;
      clr_cnt <= clr_cnt + 1;
    end
  end

  // New counters after the edge; sync inputs follow the previous counter value
  task automatic adv(input int x, input int y);
    @(posedge clk_25);
    #1;
    hsync_in  = !(x_count >= 656 && x_count < 752);
    vsync_in  = !(y_count == 490 || y_count == 491);
    active_in = (x_count < 640 && y_count < 480);
    x_count   = 10'(x);
    y_count   = 10'(y);
  endtask

  task automatic settle();
    @(negedge clk_25);
  endtask

  initial begin
    int gx;
    int gy;
    int bad;

    rst = 1'b1;
    x_count = 10'd700; y_count = 10'd10;
    hsync_in = 1'b1; vsync_in = 1'b1; active_in = 1'b0;
    cfg_vblank_only = 1'b0;
    clear_start = 1'b0; clear_color = 8'h00;
    wr_if.wr_valid = 1'b1; wr_if.wr_x = 8'd5; wr_if.wr_y = 7'd3; wr_if.wr_data = 8'hA5;

    // Reset held 3 cycles with a pending write
    repeat (3) begin adv(700, 10); settle(); end
    chk("rst_wr_ready", wr_if.wr_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_pixel", pixel_rgb, 0);
    chk("rst_hsync", hsync_out, 1);
    chk("rst_vsync", vsync_out, 1);
    chk("rst_active", active_out, 0);
    chk("rst_busy", clear_busy, 0);

    // Blanking write: (5,3) -> 3*160+5 = 485
    adv(700, 10); rst = 1'b0; settle();
    chk("bw_ready", wr_if.wr_ready, 1);
    chk("bw_addr", mem_addr, 485);
    chk("bw_we", mem_we, 1);
    chk("bw_wdata", mem_wdata, 8'hA5);
    adv(701, 10); wr_if.wr_valid = 1'b0; settle();

    // Scan row y=12 (fb row 3): columns 20..23 show A5, neighbours 0, 2-cycle latency
    for (int x = 16; x < 28; x++) begin
      adv(x, 12); settle();
      if (x >= 18) chk("scan_px", pixel_rgb, ((x - 2) >= 20 && (x - 2) <= 23) ? 8'hA5 : 8'h00);
    end
    chk("scan_active", active_out, 1);

    // hsync_in goes low for counter 656; hsync_out follows two counters later
    for (int x = 654; x < 660; x++) begin
      adv(x, 12); settle();
      if (x == 657) chk("hsync_hi", hsync_out, 1);
      if (x == 658) chk("hsync_lo", hsync_out, 0);
    end

    // Display-slot stall at (100,10): display address 2*160+25 = 345
    adv(100, 10);
    wr_if.wr_valid = 1'b1; wr_if.wr_x = 8'd7; wr_if.wr_y = 7'd2; wr_if.wr_data = 8'h3C;
    settle();
    chk("stall_ready", wr_if.wr_ready, 0);
    chk("stall_addr", mem_addr, 345);
    chk("stall_we", mem_we, 0);
    adv(101, 10); settle();
    chk("stall2_ready", wr_if.wr_ready, 1);
    chk("stall2_addr", mem_addr, 327);
    chk("stall2_we", mem_we, 1);
    adv(102, 10); wr_if.wr_valid = 1'b0; settle();
    chk("stall_ram", ram[327], 8'h3C);

    // Vblank-only mode
    adv(700, 200);
    cfg_vblank_only = 1'b1;
    wr_if.wr_valid = 1'b1; wr_if.wr_x = 8'd1; wr_if.wr_y = 7'd1; wr_if.wr_data = 8'h77;
    settle();
    chk("vb_y200_ready", wr_if.wr_ready, 0);
    adv(700, 479); settle();
    chk("vb_y479_ready", wr_if.wr_ready, 0);
    adv(0, 480); settle();
    chk("vb_y480_ready", wr_if.wr_ready, 1);
    chk("vb_y480_we", mem_we, 1);
    chk("vb_y480_addr", mem_addr, 161);
    adv(1, 480); cfg_vblank_only = 1'b0; wr_if.wr_valid = 1'b0; settle();

    // Out-of-range writes complete the handshake but never reach the RAM
    adv(700, 10); wr_if.wr_valid = 1'b1; wr_if.wr_x = 8'd200; wr_if.wr_y = 7'd0; settle();
    chk("oor_x_ready", wr_if.wr_ready, 1);
    chk("oor_x_we", mem_we, 0);
    adv(701, 10); wr_if.wr_x = 8'd0; wr_if.wr_y = 7'd120; settle();
    chk("oor_y_we", mem_we, 0);
    adv(702, 10); wr_if.wr_x = 8'd159; wr_if.wr_y = 7'd119; wr_if.wr_data = 8'h5A; settle();
    chk("edge_we", mem_we, 1);
    chk("edge_addr", mem_addr, 19199);
    adv(703, 10); wr_if.wr_valid = 1'b0; settle();

    // Clear with a simultaneous in-range write request
    adv(640, 0);
    clear_start = 1'b1; clear_color = 8'h1C;
    wr_if.wr_valid = 1'b1; wr_if.wr_x = 8'd3; wr_if.wr_y = 7'd3; wr_if.wr_data = 8'hFF;
    mon_en = 1'b1;
    settle();
    chk("clr_start_ready", wr_if.wr_ready, 0);
    chk("clr_start_we", mem_we, 0);
    chk("clr_start_busy", clear_busy, 0);
    gx = 641; gy = 0;
    adv(gx, gy); clear_start = 1'b0; wr_if.wr_x = 8'd200; settle();
    chk("clr_busy_rise", clear_busy, 1);
    chk("clr_ready", wr_if.wr_ready, 0);
    chk("clr_first_addr", mem_addr, 0);
    chk("clr_first_data", mem_wdata, 8'h1C);
    for (int i = 0; i < 60000 && clear_busy; i++) begin
      if (gx == 799) begin gx = 0; gy = (gy == 524) ? 0 : gy + 1; end
      else gx++;
      adv(gx, gy);
      clear_start = (i == 1000);
      clear_color = (i == 1000) ? 8'hE0 : 8'h1C;
      settle();
    end
    chk("clr_done", clear_busy, 0);
    adv(700, 100); mon_en = 1'b0; wr_if.wr_valid = 1'b0; clear_start = 1'b0; settle();
    chk("clr_count", clr_cnt, 19200);
    chk("clr_order_err", clr_err, 0);
    chk("clr_in_disp", disp_err, 0);
    bad = 0;
    for (int a = 0; a < 19200; a++) if (ram[a] != 8'h1C) bad++;
    chk("clr_ram_bad", bad, 0);
    chk("clr_no_overrun", ram[19200], 8'h00);

    // Scan a full active line after the clear, then the first blanked pixel
    bad = 0;
    for (int x = 0; x < 644; x++) begin
      adv(x, 4); settle();
      if (x >= 2 && x < 642 && pixel_rgb != 8'h1C) bad++;
      if (x == 642) begin
        chk("blank_px", pixel_rgb, 0);
        chk("blank_active", active_out, 0);
      end
    end
    chk("scan_clear_bad", bad, 0);

    // Reset in the middle of a clear
    adv(700, 500); clear_start = 1'b1; clear_color = 8'h03; settle();
    for (int i = 0; i < 100; i++) begin adv(700, 500); clear_start = 1'b0; settle(); end
    chk("mid_busy", clear_busy, 1);
    adv(700, 500); rst = 1'b1;
    wr_if.wr_valid = 1'b1; wr_if.wr_x = 8'd0; wr_if.wr_y = 7'd0; wr_if.wr_data = 8'hFF;
    settle();
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_ready", wr_if.wr_ready, 0);
    adv(700, 500); rst = 1'b0; settle();
    chk("mid_busy_fall", clear_busy, 0);
    chk("mid_idle_ready", wr_if.wr_ready, 1);
    chk("mid_ram_head", ram[0], 8'h03);
    chk("mid_ram_tail", ram[19199], 8'h1C);
    adv(701, 500); wr_if.wr_valid = 1'b0; settle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
